// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_MAX_DIGIT  = 9;
  localparam int unsigned BCD_ADJ_THRESH = 8;
  localparam int unsigned BCD_ADJ_VAL    = 3;

  // 10^n for elaboration-time range checks
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One-nibble reverse double-dabble correction: subtract 3 from digits >= 8.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? din - BCD_DIGIT_W'(BCD_ADJ_VAL) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// Iterative packed-BCD to binary converter (reverse double dabble, one bit per cycle).
// Define BCD_TO_BIN_CHECK_EN to flag non-decimal digits through err.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4*DIGITS-1:0]      bcd_in,
  output logic                     busy,
  output logic                     done,
  output logic [BIN_W-1:0]         bin_out,
  output logic                     err
);

  localparam int unsigned BCD_W  = BCD_DIGIT_W * DIGITS;
  localparam int unsigned WORK_W = BCD_W + BIN_W;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);

  // Binary field must hold the largest decimal value the digits can express
  if ((64'd1 << BIN_W) <= (pow10(DIGITS) - 64'd1)) begin : g_bad_width
    $error("bcd_to_bin: BIN_W too small for DIGITS");
  end

  state_e             state, state_d;
  logic [WORK_W-1:0]  work, work_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               busy_d, done_d;
  logic [BIN_W-1:0]   bin_d;
  logic [WORK_W-1:0]  shifted;
  logic [BCD_W-1:0]   adj_bcd;
  logic [WORK_W-1:0]  stepped;

  assign shifted = work >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (shifted[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .dout (adj_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  assign stepped = {adj_bcd, shifted[BIN_W-1:0]};

`ifdef BCD_TO_BIN_CHECK_EN
  logic pend, pend_d;
  logic err_q, err_d;
  logic bad_digit_c;

  // Any nibble above 9 marks the accepted operand as invalid
  always_comb begin
    bad_digit_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT)) bad_digit_c = 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state;
    work_d  = work;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = 1'b0;
    bin_d   = bin_out;
`ifdef BCD_TO_BIN_CHECK_EN
    pend_d  = pend;
    err_d   = err_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          work_d  = {bcd_in, BIN_W'(0)};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BCD_TO_BIN_CHECK_EN
          pend_d  = bad_digit_c;
`endif
        end
      end
      SHIFT: begin
        work_d = stepped;
        cnt_d  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`ifdef BCD_TO_BIN_CHECK_EN
          bin_d   = pend ? '0 : stepped[BIN_W-1:0];
          err_d   = pend;
`else
          bin_d   = stepped[BIN_W-1:0];
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
`ifdef BCD_TO_BIN_CHECK_EN
      pend    <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      work    <= work_d;
      cnt     <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      bin_out <= bin_d;
`ifdef BCD_TO_BIN_CHECK_EN
      pend    <= pend_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin at default parameters.
module tb_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  int total;
  int bad;

  bcd_to_bin u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Starts a conversion in the current cycle; returns edges to done (99 = timeout)
  // and whether busy stayed high for every cycle before done.
  task automatic convert(input logic [11:0] v, output int lat, output bit busy_ok);
    lat     = 99;
    busy_ok = 1'b1;
    bcd_in  = v;
    start   = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start  = 1'b0;
      bcd_in = ~v;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  int          lat;
  bit          bok;
  int          ndone;
  int          dlat;
  bit          hold_ok;
  bit          sweep_bin_ok;
  bit          sweep_lat_ok;
  int          first_bad;
  logic [11:0] code;

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bin",  int'(bin_out), 0);
    check("rst_err",  int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x255: latency, busy, result
    convert(12'h255, lat, bok);
    check("255_lat",  lat, 11);
    check("255_busy", int'(bok), 1);
    check("255_bin",  int'(bin_out), 255);
    check("255_err",  int'(err), 0);
    check("255_busy_at_done", int'(busy), 0);
    @(posedge clk);
    #1;
    check("255_done_pulse", int'(done), 0);
    check("255_bin_hold", int'(bin_out), 255);
    @(posedge clk);
    #1;

    // Full sweep, back-to-back starts on every done
    sweep_bin_ok = 1'b1;
    sweep_lat_ok = 1'b1;
    first_bad    = -1;
    for (int d = 0; d < 1000; d++) begin
      code = {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
      convert(code, lat, bok);
      if (lat != 11) sweep_lat_ok = 1'b0;
      if (int'(bin_out) != d || err !== 1'b0) begin
        if (first_bad < 0) first_bad = d;
        sweep_bin_ok = 1'b0;
      end
    end
    check("sweep_bin", int'(sweep_bin_ok), 1);
    check("sweep_lat", int'(sweep_lat_ok), 1);
    check("sweep_first_bad", first_bad, -1);
    @(posedge clk);
    #1;

    // 0x999 with stray starts at cycles 3 and 7
    bcd_in = 12'h999;
    start  = 1'b1;
    ndone  = 0;
    dlat   = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      start  = (n == 2 || n == 6) ? 1'b1 : 1'b0;
      bcd_in = (n == 2 || n == 6) ? 12'h111 : 12'h000;
      if (done) begin
        ndone++;
        if (dlat == 0) dlat = n;
        check("999_bin", int'(bin_out), 999);
      end
    end
    check("999_ndone", ndone, 1);
    check("999_lat", dlat, 11);
    check("999_idle_busy", int'(busy), 0);

    // Reset at cycle 5 of 0x123
    bcd_in = 12'h123;
    start  = 1'b1;
    ndone  = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      rst_n = (n == 4) ? 1'b0 : 1'b1;
      if (done) ndone++;
    end
    check("rst_mid_ndone", ndone, 0);
    check("rst_mid_bin",   int'(bin_out), 0);
    check("rst_mid_busy",  int'(busy), 0);
    convert(12'h042, lat, bok);
    check("042_lat", lat, 11);
    check("042_bin", int'(bin_out), 42);

    // 0x000: previous result held until done
    @(posedge clk);
    #1;
    bcd_in  = 12'h000;
    start   = 1'b1;
    hold_ok = 1'b1;
    lat     = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
      if (bin_out !== 10'd42) hold_ok = 1'b0;
    end
    check("000_hold", int'(hold_ok), 1);
    check("000_lat",  lat, 11);
    check("000_bin",  int'(bin_out), 0);

`ifdef BCD_TO_BIN_CHECK_EN
    @(posedge clk);
    #1;
    convert(12'h1A3, lat, bok);
    check("1a3_lat", lat, 11);
    check("1a3_err", int'(err), 1);
    check("1a3_bin", int'(bin_out), 0);
    convert(12'h100, lat, bok);
    check("100_err", int'(err), 0);
    check("100_bin", int'(bin_out), 100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
